// File: rtl/mux16_arb_pkg.sv
// Shared widths and FSM state encoding for the 16-way round-robin mux arbiter.
package mux16_arb_pkg;
    localparam int N_REQ  = 16;
    localparam int SEL_W  = 4;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;
endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping 15->0.
module rr_pick16
    import mux16_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);
    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;
    logic [SEL_W-1:0]   offset;

    // Rotating right by ptr puts the highest-priority requester at bit 0.
    assign doubled = {req, req} >> ptr;
    assign rotated = doubled[N_REQ-1:0];
    assign any     = |req;

    always_comb begin
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) offset = SEL_W'(i);
        end
    end

    assign idx = offset + ptr;
endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin owner selection for a shared 16:1 mux; registered select, one-hot grant
// and valid, with release on done, request drop, or hold timeout.
module mux16_rr_arbiter
    import mux16_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid
);
    // Handshake: a requester holds req[i] high until it owns the mux (gnt[i]=1,
    // valid=1); the owner keeps req[i] high while using it and ends ownership either
    // by pulsing done or by dropping req[i]. done is meaningless while valid=0.

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

    arb_state_t        state;
    logic [SEL_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [SEL_W-1:0]  pick_base;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;
    logic              hold_expired;
    logic              release_now;

    // One picker serves both paths: from ptr when idle, from owner+1 on release.
    assign pick_base    = (state == GRANT) ? sel + SEL_W'(1) : ptr;
    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign release_now  = done || !req[sel] || hold_expired;

    rr_pick16 u_pick (
        .req (req),
        .ptr (pick_base),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            sel      <= '0;
            valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state    <= GRANT;
                        sel      <= pick_idx;
                        gnt      <= N_REQ'(1) << pick_idx;
                        valid    <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr <= pick_base;
                        if (pick_any) begin
                            sel      <= pick_idx;
                            gnt      <= N_REQ'(1) << pick_idx;
                            hold_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                            valid <= 1'b0;
                        end
                    end else if (hold_cnt != {HOLD_W{1'b1}}) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: directed vector table plus randomized cycles checked
// against a behavioural round-robin model, all through one expected-value queue.
module tb_mux16_rr_arbiter;
    localparam int MAX_HOLD = 8;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        done;
        logic        exp_valid;
        logic [3:0]  exp_sel;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        valid;

    logic [20:0] exp_q[$];
    vec_t        vecs[$];
    int          n_checks = 0;
    int          n_pass = 0;

    // behavioural model state for the random phase
    logic        m_valid;
    logic [3:0]  m_sel;
    logic [3:0]  m_ptr;
    int          m_hc;

    mux16_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .done  (done),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] pack_exp(input logic v, input logic [3:0] s);
        logic [15:0] g;
        g = v ? (16'h0001 << s) : 16'h0000;
        return {v, g, s};
    endfunction

    task automatic add_vec(input logic r, input logic [15:0] q, input logic d,
                           input logic v, input logic [3:0] s);
        vec_t x;
        x.rst = r; x.req = q; x.done = d; x.exp_valid = v; x.exp_sel = s;
        vecs.push_back(x);
    endtask

    // Drive one cycle of inputs, queue the expectation, sample after the edge.
    task automatic run_cycle(input string name, input logic r, input logic [15:0] q,
                             input logic d, input logic [20:0] e);
        logic [20:0] got;
        logic [20:0] want;
        @(negedge clk);
        rst = r; req = q; done = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = {valid, gnt, sel};
        want = exp_q.pop_front();
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got valid=%0b gnt=%04h sel=%0d, want valid=%0b gnt=%04h sel=%0d",
                      name, got[20], got[19:4], got[3:0], want[20], want[19:4], want[3:0]);
    endtask

    function automatic void model_step(input logic r, input logic [15:0] q, input logic d);
        logic [3:0] base;
        logic       found;
        logic [3:0] idx;
        logic       rel;
        if (r) begin
            m_valid = 1'b0; m_sel = 4'h0; m_ptr = 4'h0; m_hc = 0;
            return;
        end
        rel  = m_valid && (d || !q[m_sel] || (MAX_HOLD != 0 && m_hc == MAX_HOLD - 1));
        if (m_valid && !rel) begin
            m_hc = (m_hc == 255) ? 255 : m_hc + 1;
            return;
        end
        base  = m_valid ? 4'(m_sel + 4'd1) : m_ptr;
        found = 1'b0;
        idx   = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (!found && q[4'(base + 4'(k))]) begin
                found = 1'b1;
                idx   = 4'(base + 4'(k));
            end
        end
        if (m_valid) m_ptr = base;
        if (found) begin
            m_valid = 1'b1; m_sel = idx; m_hc = 0;
        end else begin
            m_valid = 1'b0;
        end
    endfunction

    initial begin
        rst = 1'b1; req = '0; done = 1'b0;

        // reset, single grant, reset mid-grant
        add_vec(1, 16'h0000, 0, 0, 0);
        add_vec(0, 16'h0001, 0, 1, 0);
        add_vec(1, 16'h0001, 0, 0, 0);
        // two requesters at the extremes: wrap 0 -> 15 -> 0, then drop to idle
        add_vec(0, 16'h8001, 0, 1, 0);
        add_vec(0, 16'h8001, 1, 1, 15);
        add_vec(0, 16'h8001, 1, 1, 0);
        add_vec(0, 16'h0000, 0, 0, 0);
        // all requesting, done every cycle: ascending order with wrap
        add_vec(1, 16'h0000, 0, 0, 0);
        add_vec(0, 16'hFFFF, 1, 1, 0);
        for (int i = 1; i <= 17; i++) add_vec(0, 16'hFFFF, 1, 1, 4'(i));
        // hold timeout alternates between requesters 1 and 2
        add_vec(1, 16'h0000, 0, 0, 0);
        for (int i = 0; i < 8; i++) add_vec(0, 16'h0006, 0, 1, 1);
        for (int i = 0; i < 8; i++) add_vec(0, 16'h0006, 0, 1, 2);
        add_vec(0, 16'h0006, 0, 1, 1);
        // sole requester re-granted across timeouts, then released to idle
        for (int i = 0; i < 18; i++) add_vec(0, 16'h0010, 0, 1, 4);
        add_vec(0, 16'h0000, 0, 0, 4);
        add_vec(0, 16'h0000, 0, 0, 4);
        // reset in the middle of a grant restarts priority at 0
        add_vec(1, 16'h0000, 0, 0, 0);
        add_vec(0, 16'h0080, 0, 1, 7);
        for (int i = 0; i < 3; i++) add_vec(0, 16'hFFFF, 0, 1, 7);
        add_vec(1, 16'hFFFF, 0, 0, 0);
        add_vec(0, 16'hFFFF, 0, 1, 0);

        foreach (vecs[i])
            run_cycle($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].done,
                      pack_exp(vecs[i].exp_valid, vecs[i].exp_sel));

        // random traffic against the behavioural model
        model_step(1'b1, 16'h0000, 1'b0);
        run_cycle("rand_rst", 1'b1, 16'h0000, 1'b0, pack_exp(m_valid, m_sel));
        for (int c = 0; c < 400; c++) begin
            logic        r;
            logic [15:0] q;
            logic        d;
            r = ($urandom_range(0, 79) == 0);
            case ($urandom_range(0, 3))
                0: q = 16'($urandom_range(0, 65535));
                1: q = 16'h0001 << $urandom_range(0, 15);
                2: q = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                default: q = (c % 50 < 25) ? 16'hFFFF : 16'h0000;
            endcase
            d = ($urandom_range(0, 3) == 0);
            model_step(r, q, d);
            run_cycle($sformatf("rand%0d", c), r, q, d, pack_exp(m_valid, m_sel));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
